// File: rtl/sccomp_pkg.sv
// Shared types and sizes for the single-cycle computer boot path.
package sccomp_pkg;

  typedef enum logic [2:0] {HDR, LOAD, CSUM, RUN, ERR} ldr_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned HDR_BYTES  = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian words from a byte stream: a lane counter plus a
// shift register holding the lower lanes until the top byte arrives.
module byte_packer #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  take_i,
  input  logic [7:0]            byte_i,
  output logic                  word_valid_o,
  output logic [8*NBYTES-1:0]   word_o
);

  localparam int unsigned LaneW = $clog2(NBYTES);
  localparam int unsigned AccW  = 8 * (NBYTES - 1);

  logic [LaneW-1:0] lane_q;
  logic [AccW-1:0]  acc_q;

  // The top lane is combined straight from the input so the word is usable on
  // the same edge that accepts its last byte.
  assign word_valid_o = take_i && (lane_q == LaneW'(NBYTES - 1));
  assign word_o       = {byte_i, acc_q};

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      lane_q <= '0;
      acc_q  <= '0;
    end else if (take_i) begin
      lane_q <= word_valid_o ? '0 : lane_q + LaneW'(1);
      acc_q  <= {byte_i, acc_q[AccW-1:8]};
    end
  end

endmodule

// File: rtl/scimem_loader.sv
// Boot loader: packs a byte stream into words, writes them to instruction memory
// and releases the CPU once the image is in. Define CHECKSUM_ADD_EN for a trailing checksum byte.
module scimem_loader
  import sccomp_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_clrn,
  output logic        done,
  output logic        err,
  output logic [7:0]  word_cnt
);

  localparam int unsigned PackBytes = (HDR_BYTES > WORD_BYTES) ? HDR_BYTES : WORD_BYTES;

`ifdef CHECKSUM_ADD_EN
  localparam ldr_state_t AfterLoad = CSUM;
`else
  localparam ldr_state_t AfterLoad = RUN;
`endif

  ldr_state_t  state_q, state_d;
  logic        in_ready_q, imem_we_q, cpu_clrn_q, done_q, err_q;
  logic [31:0] imem_addr_q, imem_wdata_q;
  logic [7:0]  word_cnt_q, n_words_q;

  logic        take, pack_take, word_vld, last_word;
  logic [31:0] word;

  assign take      = in_valid && in_ready_q;
  // The checksum byte is not part of any word, so keep it out of the packer.
  assign pack_take = take && (state_q != CSUM);
  assign last_word = (word_cnt_q + 8'd1) == n_words_q;

  byte_packer #(
    .NBYTES(PackBytes)
  ) u_packer (
    .clk_i        (clk),
    .clr_i        (clr),
    .take_i       (pack_take),
    .byte_i       (in_data),
    .word_valid_o (word_vld),
    .word_o       (word)
  );

`ifdef CHECKSUM_ADD_EN
  logic [7:0] sum_q;
  logic       sum_ok;

  assign sum_ok = (sum_q + in_data) == 8'd0;

  always_ff @(posedge clk) begin
    if (clr) begin
      sum_q <= '0;
    end else if (state_q == LOAD && take) begin
      sum_q <= sum_q + in_data;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR: begin
        if (word_vld) begin
          if (word == 32'd0) begin
            state_d = AfterLoad;
          end else if (word > 32'(MAX_WORDS)) begin
            state_d = ERR;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (word_vld && last_word) begin
          state_d = AfterLoad;
        end
      end
`ifdef CHECKSUM_ADD_EN
      CSUM: begin
        if (take) begin
          state_d = sum_ok ? RUN : ERR;
        end
      end
`endif
      default: state_d = state_q;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= HDR;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= '0;
      cpu_clrn_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_cnt_q   <= '0;
      n_words_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == HDR) || (state_d == LOAD) || (state_d == CSUM);
      cpu_clrn_q <= (state_d == RUN);
      done_q     <= (state_d == RUN);
      err_q      <= (state_d == ERR);
      imem_we_q  <= 1'b0;
      if (state_q == HDR && word_vld) begin
        n_words_q <= word[7:0];
      end
      if (state_q == LOAD && word_vld) begin
        imem_we_q    <= 1'b1;
        imem_addr_q  <= BASE_ADDR + {22'd0, word_cnt_q, 2'b00};
        imem_wdata_q <= word;
        word_cnt_q   <= word_cnt_q + 8'd1;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_clrn   = cpu_clrn_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_scimem_loader.sv
// Bench for scimem_loader: table of images plus hand-written reset/checksum
// sequences; instruction-memory writes are checked against a scoreboard queue.
module tb_scimem_loader;

  localparam int unsigned MAXW = 64;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, imem_we, cpu_clrn, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [7:0]  word_cnt;

  scimem_loader #(
    .MAX_WORDS(MAXW),
    .BASE_ADDR(BASE)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_clrn   (cpu_clrn),
    .done       (done),
    .err        (err),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t sb[$];

  typedef struct {
    logic [31:0] n;
    int          nsend;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          slow;
    logic        exp_done;
    logic        exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write, in its cycle.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h expected no write", imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", imem_addr, e.a);
        chk("wr_data", imem_wdata, e.d);
        chk("wr_cycle", cyc, e.c);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit push, input logic [31:0] a,
                           input logic [31:0] d, input bit slow);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got in_ready=%b expected 1 within 50 cycles", in_ready);
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{a: a, d: d, c: cyc + 1});
    @(posedge clk);
    #1;
    if (slow) begin
      in_valid = 1'b0;
      in_data  = 8'hee;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_image(input logic [31:0] n, input int nsend, input logic [31:0] w0,
                            input logic [31:0] w1, input bit slow, input logic [7:0] adj);
    logic [7:0]  sum;
    logic [31:0] w;
    sum = 8'h00;
    for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8], 1'b0, 32'h0, 32'h0, slow);
    for (int i = 0; i < nsend; i++) begin
      w = (i == 0) ? w0 : (i == 1) ? w1 : (32'h5a00_0000 | i);
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], b == 3, BASE + 32'(4 * i), w, slow);
        sum = sum + w[8*b +: 8];
      end
    end
`ifdef CHECKSUM_ADD_EN
    if (n <= MAXW) send_byte((8'h00 - sum) + adj, 1'b0, 32'h0, 32'h0, slow);
`else
    if (adj != 8'h00) $display("note: checksum adjust ignored in this build");
`endif
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rst_in_ready"}, in_ready, 1'b0);
    chk({tag, "_rst_we"}, imem_we, 1'b0);
    chk({tag, "_rst_addr"}, imem_addr, BASE);
    chk({tag, "_rst_wdata"}, imem_wdata, 32'h0);
    chk({tag, "_rst_cpu_clrn"}, cpu_clrn, 1'b0);
    chk({tag, "_rst_done"}, done, 1'b0);
    chk({tag, "_rst_err"}, err, 1'b0);
    chk({tag, "_rst_word_cnt"}, word_cnt, 8'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic check_end(input string tag, input logic exp_done, input logic exp_err,
                           input logic [7:0] exp_cnt);
    @(negedge clk);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_cpu_clrn"}, cpu_clrn, exp_done);
    chk({tag, "_word_cnt"}, word_cnt, exp_cnt);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    // Trailing bytes must be refused and change nothing.
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_tail_ready"}, in_ready, 1'b0);
    end
    in_valid = 1'b0;
    chk({tag, "_tail_word_cnt"}, word_cnt, exp_cnt);
    chk({tag, "_tail_done"}, done, exp_done);
    chk({tag, "_pending_writes"}, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n: 32'd2,   nsend: 2,  w0: 32'h2001_0013, w1: 32'hddcc_bbaa, slow: 1'b0,
                exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 8'd2};
    vecs[1] = '{n: 32'd2,   nsend: 2,  w0: 32'h2001_0013, w1: 32'hddcc_bbaa, slow: 1'b1,
                exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 8'd2};
    vecs[2] = '{n: 32'd0,   nsend: 0,  w0: 32'h0,         w1: 32'h0,         slow: 1'b0,
                exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 8'd0};
    vecs[3] = '{n: 32'd65,  nsend: 0,  w0: 32'h0,         w1: 32'h0,         slow: 1'b0,
                exp_done: 1'b0, exp_err: 1'b1, exp_cnt: 8'd0};
    vecs[4] = '{n: 32'd1,   nsend: 1,  w0: 32'hcafe_f00d, w1: 32'h0,         slow: 1'b1,
                exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 8'd1};
    vecs[5] = '{n: 32'd64,  nsend: 64, w0: 32'h0102_0304, w1: 32'hffff_ffff, slow: 1'b0,
                exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 8'd64};
    vecs[6] = '{n: 32'h100, nsend: 0,  w0: 32'h0,         w1: 32'h0,         slow: 1'b0,
                exp_done: 1'b0, exp_err: 1'b1, exp_cnt: 8'd0};

    for (int v = 0; v < 7; v++) begin
      do_reset($sformatf("v%0d", v));
      send_image(vecs[v].n, vecs[v].nsend, vecs[v].w0, vecs[v].w1, vecs[v].slow, 8'h00);
      check_end($sformatf("v%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_cnt);
    end

    // clr after two payload bytes of the first word: partial word is dropped.
    do_reset("midclr");
    for (int b = 0; b < 4; b++) send_byte((b == 0) ? 8'd2 : 8'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    send_byte(8'h13, 1'b0, 32'h0, 32'h0, 1'b0);
    send_byte(8'h00, 1'b0, 32'h0, 32'h0, 1'b0);
    in_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midclr_cpu_clrn", cpu_clrn, 1'b0);
    chk("midclr_we", imem_we, 1'b0);
    chk("midclr_word_cnt", word_cnt, 8'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    send_image(32'd1, 1, 32'h1122_3344, 32'h0, 1'b0, 8'h00);
    check_end("midclr_new", 1'b1, 1'b0, 8'd1);

`ifdef CHECKSUM_ADD_EN
    do_reset("csum_ok");
    send_image(32'd1, 1, 32'h0403_0201, 32'h0, 1'b0, 8'h00);
    check_end("csum_ok", 1'b1, 1'b0, 8'd1);

    do_reset("csum_bad");
    send_image(32'd1, 1, 32'h0403_0201, 32'h0, 1'b0, 8'hff);
    check_end("csum_bad", 1'b0, 1'b1, 8'd1);
`endif

    repeat (2) @(negedge clk);
    chk("final_pending_writes", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
